wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the pipeline writeback stage and an auxiliary multi-cycle result source, such as a multiply/divide or coprocessor unit that returns results asynchronously to the pipeline. Auxiliary results are held in a small FIFO. The block drives registered write-port outputs with the same one-cycle latency as the writeback stage. Pipeline writes have priority, and a starvation counter forces a one-cycle pipeline stall so that buffered auxiliary writes always drain.

---
 rtl/wb_port_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register-file write port between the pipeline writeback stage
// and an auxiliary multi-cycle result source. Auxiliary results wait in a
// small FIFO. Pipeline writes win by default. If the FIFO head waits too
// long, a one-cycle STEAL stalls the pipeline so that the head can drain.
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_reg,
    input  logic [31:0] pipe_data,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_reg,
    input  logic [31:0] aux_data,
    output logic        stall_pipe,
    output logic        aux_pending,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX) + 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
    localparam logic [SW-1:0] STARVE_TOP  = SW'(STARVE_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        STEAL = 1'b1
    } state_t;

    state_t        state;
    logic [4:0]    fifo_reg  [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;
    logic          pipe_req;
    logic          push;
    logic          grant_aux;
    logic          grant_pipe;

    // Requests and grants for this cycle; a STEAL cycle ignores the pipeline and always takes the head
    always_comb begin
        aux_ready   = (count < DEPTH_C) && !rst;
        aux_pending = (count != '0);
        stall_pipe  = (state == STEAL);
        pipe_req    = pipe_we && (pipe_reg != 5'd0) && (state != STEAL);
        grant_aux   = aux_pending && (!pipe_req || (state == STEAL));
        grant_pipe  = pipe_req && !grant_aux;
        push        = aux_valid && aux_ready && (aux_reg != 5'd0);
    end

    // FIFO storage; results for $0 are handshaken but never stored
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= aux_reg;
            fifo_data[wr_ptr] <= aux_data;
        end
    end

    // FIFO pointers and occupancy; a push and a pop in the same cycle leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (grant_aux) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, grant_aux})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Starvation counter and IDLE/STEAL machine that forces the head through after STARVE_MAX lost cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            state      <= IDLE;
        end else begin
            if (!aux_pending || grant_aux) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_TOP) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            if (state == STEAL) begin
                state <= IDLE;
            end else if (aux_pending && !grant_aux && (starve_cnt == STARVE_LAST)) begin
                state <= STEAL;
            end
        end
    end

    // Registered write port; address and data hold their previous values when nothing is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_we <= grant_pipe || grant_aux;
            if (grant_aux) begin
                rf_waddr <= fifo_reg[rd_ptr];
                rf_wdata <= fifo_data[rd_ptr];
            end else if (grant_pipe) begin
                rf_waddr <= pipe_reg;
                rf_wdata <= pipe_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// The stimulus process posts each expected register-file write, with the cycle
// in which it must appear, to a scoreboard. A separate monitor on the falling
// edge matches every rf_we pulse against that scoreboard.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_reg;
    logic [31:0] aux_data;
    logic        stall_pipe;
    logic        aux_pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cycle;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];

    wb_port_arbiter #(
        .DEPTH(2),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pipe_we(pipe_we),
        .pipe_reg(pipe_reg),
        .pipe_data(pipe_data),
        .aux_valid(aux_valid),
        .aux_ready(aux_ready),
        .aux_reg(aux_reg),
        .aux_data(aux_data),
        .stall_pipe(stall_pipe),
        .aux_pending(aux_pending),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle index, advanced at each rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // Global time limit so that the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] time limit reached");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input int cycle, input logic [4:0] waddr, input logic [31:0] wdata);
        exp_t e;
        e.cycle = cycle;
        e.waddr = waddr;
        e.wdata = wdata;
        sb.push_back(e);
    endtask

    task automatic check_output(input string name, input logic actual, input logic required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got %0b, required %0b (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Monitor: flags expected writes that never appeared, then matches each rf_we pulse against the scoreboard
    always @(negedge clk) begin
        int idx;
        if (rst === 1'b0) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cycle < cyc) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL missing_write: cycle %0d lacked required write reg %0d data %h",
                             sb[i].cycle, sb[i].waddr, sb[i].wdata);
                    sb.delete(i);
                end
            end
            if (rf_we === 1'b1) begin
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].cycle == cyc) idx = i;
                end
                checks++;
                if (idx < 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_write: got reg %0d data %h in cycle %0d, required no write",
                             rf_waddr, rf_wdata, cyc);
                end else begin
                    if (rf_waddr !== sb[idx].waddr || rf_wdata !== sb[idx].wdata) begin
                        failures++;
                        $display("[TB] FAIL write_content: cycle %0d got reg %0d data %h, required reg %0d data %h",
                                 cyc, rf_waddr, rf_wdata, sb[idx].waddr, sb[idx].wdata);
                    end
                    sb.delete(idx);
                end
            end
        end
    end

    // Continuous pipeline writes for n cycles with hand-computed stall/pending/ready patterns per offset.
    // The write presented in a stall cycle is held and presented again in the next cycle.
    // mode 0: three auxiliary results that fill the FIFO; mode 1: one auxiliary result that starves.
    task automatic apply_burst(input int n, input int mode, input logic [31:0] stall_mask,
                               input logic [31:0] pend_mask, input logic [31:0] ready_mask);
        int k = 0;
        int c0 = 0;
        for (int off = 0; off < n; off++) begin
            step();
            if (off == 0) c0 = cyc;
            pipe_we   = 1'b1;
            pipe_reg  = (mode == 0) ? 5'(10 + (k % 16)) : 5'd9;
            pipe_data = (mode == 0) ? 32'(32'h1000 + k) : 32'(32'h900 + k);
            if (!stall_mask[off]) begin
                expect_write(cyc + 1, pipe_reg, pipe_data);
                k++;
            end
            aux_valid = 1'b0;
            if (mode == 0) begin
                if (off == 0) begin
                    aux_valid = 1'b1; aux_reg = 5'd20; aux_data = 32'hA0;
                    expect_write(c0 + 6,  5'd20, 32'hA0);
                    expect_write(c0 + 11, 5'd21, 32'hB0);
                    expect_write(c0 + 16, 5'd22, 32'hC0);
                end else if (off == 1) begin
                    aux_valid = 1'b1; aux_reg = 5'd21; aux_data = 32'hB0;
                end else if (off <= 6) begin
                    aux_valid = 1'b1; aux_reg = 5'd22; aux_data = 32'hC0;
                end
            end else if (off == 0) begin
                aux_valid = 1'b1; aux_reg = 5'd3; aux_data = 32'h33;
                expect_write(c0 + 6, 5'd3, 32'h33);
            end
            check_output("stall_pipe", stall_pipe, stall_mask[off]);
            check_output("aux_pending", aux_pending, pend_mask[off]);
            check_output("aux_ready", aux_ready, ready_mask[off]);
        end
        step();
        pipe_we   = 1'b0;
        aux_valid = 1'b0;
        repeat (3) step();
    endtask

    // Directed stimulus sequence
    initial begin
        int c0;
        rst       = 1'b1;
        pipe_we   = 1'b0;
        pipe_reg  = 5'd0;
        pipe_data = 32'd0;
        aux_valid = 1'b0;
        aux_reg   = 5'd0;
        aux_data  = 32'd0;

        #1;
        check_output("reset_rf_we", rf_we, 1'b0);
        check_output("reset_rf_waddr_zero", (rf_waddr === 5'd0), 1'b1);
        check_output("reset_rf_wdata_zero", (rf_wdata === 32'd0), 1'b1);
        check_output("reset_stall", stall_pipe, 1'b0);
        check_output("reset_pending", aux_pending, 1'b0);
        check_output("reset_ready", aux_ready, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;
        check_output("ready_after_reset", aux_ready, 1'b1);

        // Pipeline only, then a write to $0 that must not appear
        step();
        pipe_we = 1'b1; pipe_reg = 5'd8; pipe_data = 32'hDEADBEEF;
        expect_write(cyc + 1, 5'd8, 32'hDEADBEEF);
        step();
        pipe_reg = 5'd0; pipe_data = 32'h12345678;
        step();
        pipe_we = 1'b0;
        repeat (3) step();

        // Auxiliary only: two results drain in order, two cycles after each push
        step();
        aux_valid = 1'b1; aux_reg = 5'd5; aux_data = 32'h11;
        check_output("aux_ready_first", aux_ready, 1'b1);
        expect_write(cyc + 2, 5'd5, 32'h11);
        step();
        aux_reg = 5'd6; aux_data = 32'h22;
        check_output("aux_ready_second", aux_ready, 1'b1);
        check_output("aux_pending_second", aux_pending, 1'b1);
        expect_write(cyc + 2, 5'd6, 32'h22);
        step();
        aux_valid = 1'b0;
        repeat (4) step();

        // Full FIFO under continuous pipeline writes: stalls at offsets 5, 10 and 15
        apply_burst(18, 0, 32'h0000_8420, 32'h0000_FFFE, 32'h0003_F843);

        // Starvation of a single result: stall at offset 5, result written at offset 6
        apply_burst(8, 1, 32'h0000_0020, 32'h0000_003E, 32'h0000_00FF);

        // Simultaneous push and pop at count 1 for 10 cycles
        step();
        aux_valid = 1'b1; aux_reg = 5'd1; aux_data = 32'h500;
        expect_write(cyc + 2, 5'd1, 32'h500);
        for (int i = 1; i <= 10; i++) begin
            step();
            aux_reg  = 5'(1 + i);
            aux_data = 32'(32'h500 + i);
            expect_write(cyc + 2, aux_reg, aux_data);
            check_output("pushpop_pending", aux_pending, 1'b1);
            check_output("pushpop_ready", aux_ready, 1'b1);
        end
        step();
        aux_valid = 1'b0;
        repeat (4) step();

        // Reset mid-operation with two entries queued and a write on the port
        step();
        c0 = cyc;
        pipe_we = 1'b1; pipe_reg = 5'd12; pipe_data = 32'hC0;
        aux_valid = 1'b1; aux_reg = 5'd13; aux_data = 32'hD0;
        expect_write(c0 + 1, 5'd12, 32'hC0);
        step();
        pipe_data = 32'hC1;
        aux_reg = 5'd14; aux_data = 32'hD1;
        step();
        aux_valid = 1'b0;
        check_output("pre_reset_rf_we", rf_we, 1'b1);
        check_output("pre_reset_full", aux_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_output("midreset_rf_we", rf_we, 1'b0);
        check_output("midreset_stall", stall_pipe, 1'b0);
        check_output("midreset_pending", aux_pending, 1'b0);
        check_output("midreset_ready", aux_ready, 1'b0);
        pipe_we = 1'b0;
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        check_output("post_reset_ready", aux_ready, 1'b1);
        check_output("post_reset_pending", aux_pending, 1'b0);
        repeat (6) step();

        // Bounded drain of any outstanding expectations
        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d writes outstanding, required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
